lsu_bus_master: RTL and testbench

Load/store unit sitting directly downstream of the instruction decoder in the single-cycle RV32I core. Takes the decoded bus write-enable, the funct3 access-size code, the ALU-computed address and rs2 store data, and runs a multi-cycle handshake on the data bus. It stalls the core until the access retires, aligns and extends load data for register writeback, and reports misalignment, illegal size and bus-timeout faults.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_load_align.sv | 40 ++++
 rtl/lsu_bus_master.sv | 173 +++++++++++++++++
 tb/tb_lsu_bus_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_state_e   : bus-master FSM states
//   lsu_fault_e   : fault cause encoding driven on fault_cause
//   F3_*          : funct3 access-size codes
//   f3_legal      : funct3 legality for a load or a store
//   f3_misaligned : natural-alignment check for a funct3/offset pair
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_e;

   typedef enum logic [1:0] {
      FLT_NONE     = 2'b00,
      FLT_MISALIGN = 2'b01,
      FLT_SIZE     = 2'b10,
      FLT_TIMEOUT  = 2'b11
   } lsu_fault_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned variants exist only for loads.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   // f3[1:0] encodes the access size for every legal code.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      case (f3[1:0])
         2'b01:   bad = off[0];
         2'b10:   bad = (off != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/halfword lane of a bus
// word and sign- or zero-extends it to 32 bits.
//   funct3 : load access code (LB/LH/LW/LBU/LHU)
//   offset : byte offset within the word (addr[1:0])
//   word   : raw 32-bit bus read data
//   result : extended value for register writeback
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      // NOTE: every combinational output is given a default first so no latch is inferred.
      lane_b = 8'h00;
      result = word;
      case (offset)
         2'd0: lane_b = word[7:0];
         2'd1: lane_b = word[15:8];
         2'd2: lane_b = word[23:16];
         2'd3: lane_b = word[31:24];
         default: lane_b = 8'h00;
      endcase
      lane_h = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    result = {{24{lane_b[7]}}, lane_b};
         F3_BU:   result = {24'h000000, lane_b};
         F3_H:    result = {{16{lane_h[15]}}, lane_h};
         F3_HU:   result = {16'h0000, lane_h};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master. Validates a decoded load/store, runs a
// request/ready handshake on the data bus, stalls the core until the access
// retires and reports misalignment, illegal-size and timeout faults.
//   clk, reset_n                    : clock, async active-low reset
//   req_valid/we/strb/addr/wdata    : request from EX (held stable while stall)
//   stall                           : hold PC and pipeline
//   rdata, rdata_valid              : extended load result and its retire pulse
//   fault, fault_cause              : fault retire pulse and cause
//   bus_req/we/addr/be/wdata        : registered bus request
//   bus_ready, bus_rdata            : bus completion and read data
module lsu_bus_master
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_strb,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

   lsu_state_e  state, state_next;
   lsu_fault_e  req_cause;
   logic        accept, reject, ready_hit, timeout;
   logic [7:0]  wait_cnt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] load_data;

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state is updated only with non-blocking assignments.
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_cause  = FLT_NONE;
      accept     = 1'b0;
      reject     = 1'b0;
      ready_hit  = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (!f3_legal(req_we, req_strb))                   req_cause = FLT_SIZE;
               else if (f3_misaligned(req_strb, req_addr[1:0]))   req_cause = FLT_MISALIGN;
               accept     = (req_cause == FLT_NONE);
               reject     = !accept;
               state_next = accept ? ACCESS : DONE;
            end
         end
         ACCESS: begin
            // wait_cnt holds the number of the current ACCESS cycle, so
            // ready in the last allowed cycle still wins over the timeout.
            if (bus_ready) begin
               ready_hit  = 1'b1;
               state_next = DONE;
            end else if (wait_cnt == TO_LIMIT) begin
               timeout    = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Gated with reset_n so stall falls immediately when reset aborts a transfer.
   assign stall = reset_n & (((state == IDLE) & req_valid) | (state == ACCESS));

   // Store lane placement; loads read the full word.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = req_wdata;
      if (req_we) begin
         case (req_strb)
            F3_B: begin
               be_next    = 4'b0001 << req_addr[1:0];
               wdata_next = {4{req_wdata[7:0]}};
            end
            F3_H: begin
               be_next    = 4'b0011 << {req_addr[1], 1'b0};
               wdata_next = {2{req_wdata[15:0]}};
            end
            default: begin
               be_next    = 4'b1111;
               wdata_next = req_wdata;
            end
         endcase
      end
   end

   lsu_load_align u_align (
      .funct3 (f3_q),
      .offset (off_q),
      .word   (bus_rdata),
      .result (load_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= 32'h0;
         bus_be      <= 4'h0;
         bus_wdata   <= 32'h0;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         wait_cnt    <= 8'd0;
         rdata       <= 32'h0;
         rdata_valid <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= FLT_NONE;
      end else begin
         rdata_valid <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= FLT_NONE;
         if (accept) begin
            bus_req   <= 1'b1;
            bus_we    <= req_we;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_be    <= be_next;
            bus_wdata <= wdata_next;
            f3_q      <= req_strb;
            off_q     <= req_addr[1:0];
            wait_cnt  <= 8'd1;
         end
         if (reject) begin
            fault       <= 1'b1;
            fault_cause <= req_cause;
         end
         if (state == ACCESS && !ready_hit && !timeout) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (ready_hit) begin
            bus_req  <= 1'b0;
            wait_cnt <= 8'd0;
            if (!bus_we) begin
               rdata       <= load_data;
               rdata_valid <= 1'b1;
            end
         end
         if (timeout) begin
            bus_req     <= 1'b0;
            wait_cnt    <= 8'd0;
            rdata       <= 32'h0;
            fault       <= 1'b1;
            fault_cause <= FLT_TIMEOUT;
         end
      end
   end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed cases followed by
// randomized transactions compared against a transaction-level model.
module tb_lsu_bus_master;

   localparam int TO = 4;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_strb;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        fault;
   logic [1:0]  fault_cause;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_rdata;

   lsu_bus_master #(.TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_strb    (req_strb),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .stall       (stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .fault       (fault),
      .fault_cause (fault_cause),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_be      (bus_be),
      .bus_wdata   (bus_wdata),
      .bus_ready   (bus_ready),
      .bus_rdata   (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [1:0] model_cause(input logic we, input logic [2:0] f3,
                                              input logic [31:0] addr);
      int size;
      logic legal;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 2'b10;
      size = 1 << f3[1:0];
      if ((int'(addr[1:0]) % size) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [1:0] off);
      int size;
      if (!we) return 4'hF;
      size = 1 << f3[1:0];
      return 4'(((1 << size) - 1) << off);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] b, h;
      b = {24'h0, wd[7:0]};
      h = {16'h0, wd[15:0]};
      case (f3)
         3'd0:    return b * 32'h0101_0101;
         3'd1:    return h * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
      logic [31:0] s;
      s = word >> (8 * int'(off));
      case (f3)
         3'd0:    return 32'(int'(byte'(s[7:0])));
         3'd4:    return {24'h0, s[7:0]};
         3'd1:    return 32'(int'(shortint'(s[15:0])));
         3'd5:    return {16'h0, s[15:0]};
         default: return word;
      endcase
   endfunction

   // One full transaction; delay = number of ACCESS cycles without ready
   // before ready is given (delay >= TO means ready never arrives in time).
   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rword, input int delay);
      logic [1:0] cause, exp_code;
      logic       exp_fault, exp_valid, done_seen;
      int         exp_acc, n_acc;
      cause     = model_cause(we, f3, addr);
      exp_acc   = (cause != 2'b00) ? 0 : ((delay < TO) ? delay + 1 : TO);
      exp_fault = (cause != 2'b00) || (delay >= TO);
      exp_code  = (cause != 2'b00) ? cause : ((delay >= TO) ? 2'b11 : 2'b00);
      exp_valid = !exp_fault && !we;

      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_strb = f3; req_addr = addr; req_wdata = wdata;
      bus_ready = 1'b0;
      @(negedge clk);
      check("idle_stall", stall, 1);
      check("idle_bus_req", bus_req, 0);

      n_acc = 0;
      done_seen = 1'b0;
      for (int k = 0; k < TO + 3 && !done_seen; k++) begin
         @(posedge clk); #1;
         bus_ready = (k == delay);
         bus_rdata = (k == delay) ? rword : $urandom;
         @(negedge clk);
         if (bus_req) begin
            n_acc++;
            check("acc_stall", stall, 1);
            check("acc_addr", bus_addr, {addr[31:2], 2'b00});
            check("acc_we", bus_we, we);
            check("acc_be", bus_be, model_be(we, f3, addr[1:0]));
            if (we) check("acc_wdata", bus_wdata, model_wdata(f3, wdata));
         end else begin
            done_seen = 1'b1;
            if (exp_valid)                       exp_rdata = model_load(f3, addr[1:0], rword);
            else if (cause == 2'b00 && exp_fault) exp_rdata = 32'h0;
            check("done_stall", stall, 0);
            check("done_fault", fault, exp_fault);
            check("done_cause", fault_cause, exp_code);
            check("done_rvalid", rdata_valid, exp_valid);
            check("done_rdata", rdata, exp_rdata);
         end
      end
      check("done_reached", done_seen, 1);
      check("access_cycles", n_acc, exp_acc);

      // Retire cycle passed: request drops, stray ready must be ignored.
      @(posedge clk); #1;
      req_valid = 1'b0;
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      @(negedge clk);
      check("post_stall", stall, 0);
      check("post_bus_req", bus_req, 0);
      check("post_fault", fault, 0);
      check("post_rvalid", rdata_valid, 0);
      check("post_rdata", rdata, exp_rdata);
      bus_ready = 1'b0;
   endtask

   logic        r_we;
   logic [2:0]  r_f3;
   logic [31:0] r_addr;
   int          r_size;

   initial begin
      reset_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_strb = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      bus_ready = 1'b0; bus_rdata = 32'h0;
      exp_rdata = 32'h0;
      repeat (2) @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_bus_req", bus_req, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rvalid", rdata_valid, 0);
      check("rst_fault", fault, 0);
      check("rst_cause", fault_cause, 0);
      check("rst_bus_be", bus_be, 0);
      check("rst_bus_addr", bus_addr, 0);
      reset_n = 1'b1;

      // Directed cases
      run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
      check("lw_rdata", rdata, 32'hDEAD_BEEF);
      run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8000_0000, 0);
      check("lb_rdata", rdata, 32'hFFFF_FF80);
      run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8000_0000, 1);
      check("lbu_rdata", rdata, 32'h0000_0080);
      run_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 2);
      check("lhu_rdata", rdata, 32'h0000_BEEF);
      run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_0000, 0);
      check("lh_rdata", rdata, 32'hFFFF_8001);
      run_txn(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0, 0);
      check("sb_keeps_rdata", rdata, 32'hFFFF_8001);
      run_txn(1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0, 1);
      run_txn(1'b1, 3'b010, 32'h0000_0302, 32'h1111_2222, 32'h0, 0);
      run_txn(1'b0, 3'b011, 32'h0000_0300, 32'h0, 32'h0, 0);
      run_txn(1'b1, 3'b100, 32'h0000_0300, 32'h0, 32'h0, 0);
      run_txn(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h1234_5678, TO - 1);
      check("ready_at_limit", rdata, 32'h1234_5678);
      run_txn(1'b0, 3'b010, 32'h0000_0504, 32'h0, 32'h5555_5555, TO + 5);
      check("timeout_rdata", rdata, 32'h0);
      run_txn(1'b1, 3'b010, 32'h0000_0508, 32'hCAFE_F00D, 32'h0, TO + 5);

      // Reset during the second ACCESS wait cycle
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_strb = 3'b010; req_addr = 32'h0000_0400;
      bus_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2;
      check("mid_bus_req", bus_req, 1);
      reset_n = 1'b0;
      #1;
      check("abort_bus_req", bus_req, 0);
      check("abort_stall", stall, 0);
      check("abort_fault", fault, 0);
      check("abort_rvalid", rdata_valid, 0);
      req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_rdata = 32'h0;
      run_txn(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'hA1B2_C3D4, 1);
      check("lw_after_reset", rdata, 32'hA1B2_C3D4);

      // Randomized transactions
      for (int i = 0; i < 200; i++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_f3   = 3'($urandom_range(0, 7));
         r_addr = $urandom;
         r_size = 1 << r_f3[1:0];
         if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~32'(r_size - 1);
         run_txn(r_we, r_f3, r_addr, $urandom, $urandom, $urandom_range(0, TO + 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
